// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit a+b+c_in through one 4-bit CLA slice, one nibble per cycle, LSB first.
// Latency: WIDTH/4 cycles from accept to out_valid; peak rate one operation per WIDTH/4+2 cycles.
// Backpressure: result held while out_ready low; in_ready only in IDLE. Define NSA_OVERFLOW_EN for ovf.

module nsa_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c;
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef NSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    op_t              op_q, op_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
`ifdef NSA_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_s;
    logic       nib_co;
    logic       last_nib;

    // Operand nibble select for the shared slice
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a = op_q.a[4*i +: 4];
                nib_b = op_q.b[4*i +: 4];
            end
        end
    end

    nsa_cla4 u_cla (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    assign last_nib  = (idx_q == IDXW'(N - 1));
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
`ifdef NSA_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
`ifdef NSA_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = ST_RUN;
                    op_d    = '{a: a, b: b};
                    carry_d = c_in;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        acc_d[4*i +: 4] = nib_s;
                    end
                end
                carry_d = nib_co;
                idx_d   = idx_q + IDXW'(1);
                if (last_nib) begin
                    // Final nibble goes straight into the output register, not via acc_q
                    state_d = ST_DONE;
                    idx_d   = '0;
                    sum_d   = acc_d;
                    c_out_d = nib_co;
`ifdef NSA_OVERFLOW_EN
                    ovf_d   = (op_q.a[WIDTH-1] == op_q.b[WIDTH-1]) &&
                              (acc_d[WIDTH-1] != op_q.a[WIDTH-1]);
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef NSA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
`ifdef NSA_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH 4, 16 and 32 against an arithmetic reference model.
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  iv, orr, ov, ir, co;
    logic [31:0] av_r, bv_r;
    logic        ci_r;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [31:0] sum32;
`ifdef NSA_OVERFLOW_EN
    logic [2:0]  of;
`endif
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av_r[3:0]), .b(bv_r[3:0]), .c_in(ci_r), .out_valid(ov[0]),
        .out_ready(orr[0]), .sum(sum4), .c_out(co[0])
`ifdef NSA_OVERFLOW_EN
        , .ovf(of[0])
`endif
    );
    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av_r[15:0]), .b(bv_r[15:0]), .c_in(ci_r), .out_valid(ov[1]),
        .out_ready(orr[1]), .sum(sum16), .c_out(co[1])
`ifdef NSA_OVERFLOW_EN
        , .ovf(of[1])
`endif
    );
    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av_r), .b(bv_r), .c_in(ci_r), .out_valid(ov[2]),
        .out_ready(orr[2]), .sum(sum32), .c_out(co[2])
`ifdef NSA_OVERFLOW_EN
        , .ovf(of[2])
`endif
    );

    function automatic logic [31:0] f_sum(input int k);
        case (k)
            0:       return 32'(sum4);
            1:       return 32'(sum16);
            default: return sum32;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the result handshake.
    task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input int hold);
        int k, n, t;
        longint unsigned mask, full;
        logic [31:0] exp_s;
        logic exp_c;
`ifdef NSA_OVERFLOW_EN
        longint sa, sb, ss, lim;
        logic exp_o;
`endif
        k = (w == 4) ? 0 : (w == 16) ? 1 : 2;
        n = w / 4;
        mask  = (64'd1 << w) - 64'd1;
        full  = (64'(av) & mask) + (64'(bv) & mask) + 64'(ci);
        exp_s = 32'(full & mask);
        exp_c = 1'((full >> w) & 64'd1);
`ifdef NSA_OVERFLOW_EN
        lim = longint'(64'd1 << (w - 1));
        sa  = longint'(64'(av) & mask);
        sb  = longint'(64'(bv) & mask);
        if (sa >= lim) sa -= 2 * lim;
        if (sb >= lim) sb -= 2 * lim;
        ss    = sa + sb + longint'(ci);
        exp_o = (ss >= lim) || (ss < -lim);
`endif
        orr[k] = (hold == 0);
        iv[k]  = 1'b1;
        av_r   = av;
        bv_r   = bv;
        ci_r   = ci;
        t = 0;
        while (!ir[k] && t < 64) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 64'(ir[k]), 64'd1);
        @(negedge clk);
        iv[k] = 1'b0;
        av_r  = $urandom;
        bv_r  = $urandom;
        ci_r  = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            chk("run_out_valid", 64'(ov[k]), 64'd0);
            chk("run_in_ready", 64'(ir[k]), 64'd0);
            @(negedge clk);
        end
        chk("done_out_valid", 64'(ov[k]), 64'd1);
        chk("done_sum", 64'(f_sum(k)), 64'(exp_s));
        chk("done_c_out", 64'(co[k]), 64'(exp_c));
`ifdef NSA_OVERFLOW_EN
        chk("done_ovf", 64'(of[k]), 64'(exp_o));
`endif
        for (int h = 0; h < hold; h++) begin
            iv[k] = 1'($urandom_range(0, 1));
            av_r  = $urandom;
            @(negedge clk);
            chk("hold_out_valid", 64'(ov[k]), 64'd1);
            chk("hold_in_ready", 64'(ir[k]), 64'd0);
            chk("hold_sum", 64'(f_sum(k)), 64'(exp_s));
            chk("hold_c_out", 64'(co[k]), 64'(exp_c));
        end
        iv[k]  = 1'b0;
        orr[k] = 1'b1;
        @(negedge clk);
        orr[k] = 1'b0;
        chk("post_out_valid", 64'(ov[k]), 64'd0);
        chk("post_in_ready", 64'(ir[k]), 64'd1);
        chk("post_sum_held", 64'(f_sum(k)), 64'(exp_s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iv = '0; orr = '0; av_r = '0; bv_r = '0; ci_r = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", 64'(ir[k]), 64'd1);
            chk("rst_out_valid", 64'(ov[k]), 64'd0);
            chk("rst_sum", 64'(f_sum(k)), 64'd0);
            chk("rst_c_out", 64'(co[k]), 64'd0);
`ifdef NSA_OVERFLOW_EN
            chk("rst_ovf", 64'(of[k]), 64'd0);
`endif
        end
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16, 32'h1234, 32'h4321, 1'b0, 0);
        chk("dir_5555", 64'(sum16), 64'h5555);
        do_op(16, 32'hFFFF, 32'h0000, 1'b1, 0);
        chk("dir_carry_chain", 64'({co[1], sum16}), 64'h10000);
        do_op(16, 32'hFFFF, 32'hFFFF, 1'b1, 5);
        chk("dir_hold_sum", 64'({co[1], sum16}), 64'h1FFFF);
`ifdef NSA_OVERFLOW_EN
        do_op(16, 32'h7FFF, 32'h0001, 1'b0, 0);
        chk("dir_ovf_pos", 64'({of[1], co[1], sum16}), 64'h28000);
        do_op(16, 32'h8000, 32'h8000, 1'b0, 0);
        chk("dir_ovf_neg", 64'({of[1], co[1], sum16}), 64'h30000);
        do_op(16, 32'h1234, 32'h4321, 1'b0, 1);
        chk("dir_no_ovf", 64'(of[1]), 64'd0);
        do_op(16, 32'hFFFF, 32'hFFFF, 1'b1, 0);
`endif

        // Abandon an operation with reset during its second RUN cycle
        iv[1] = 1'b1; av_r = 32'h00FF; bv_r = 32'h0001; ci_r = 1'b0; orr[1] = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(ov[1]), 64'd0);
        chk("midrst_in_ready", 64'(ir[1]), 64'd1);
        chk("midrst_sum", 64'(sum16), 64'd0);
        chk("midrst_c_out", 64'(co[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_result", 64'(ov[1]), 64'd0);
        end
        orr[1] = 1'b0;
        do_op(16, 32'h0001, 32'h0001, 1'b0, 0);
        chk("midrst_next_sum", 64'(sum16), 64'h0002);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                logic [31:0] ra, rb;
                ra = $urandom;
                rb = $urandom;
                if (i % 8 == 0) ra = 32'hFFFF_FFFF;
                do_op((k == 0) ? 4 : (k == 1) ? 16 : 32, ra, rb,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
